// File: rtl/sd_rrarb_full.sv
// Round-robin arbiter that merges srdy/drdy requesters into one channel through a 2-entry registered buffer.
// Optional packet lock (grant held until an eop beat transfers) is enabled by defining SD_RRARB_PKTLOCK_EN.
module sd_rrarb_full #(
  parameter int inputs = 4,
  parameter int width  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [inputs-1:0]         c_srdy,
  output logic [inputs-1:0]         c_drdy,
  input  logic [inputs*width-1:0]   c_data,
  input  logic [inputs-1:0]         c_eop,
  output logic                      p_srdy,
  input  logic                      p_drdy,
  output logic [width-1:0]          p_data,
  output logic                      p_eop,
  output logic [inputs-1:0]         p_grant
);
  localparam int IW = (inputs > 1) ? $clog2(inputs) : 1;

  logic [1:0]        count;
  logic              srdy_p1;
  logic [IW-1:0]     ptr;
  logic [width-1:0]  hd_data, tl_data;
  logic              hd_eop, tl_eop;
  logic [inputs-1:0] hd_gnt, tl_gnt;

  logic [inputs-1:0] req, gnt_oh;
  logic [IW-1:0]     gnt_idx;
  logic [IW:0]       cand;
  logic              gnt_vld, space, push, pop;
  logic [width-1:0]  beat_data;
  logic              beat_eop;
  logic              load_hd_beat, load_hd_tail, load_tl;

`ifdef SD_RRARB_PKTLOCK_EN
  logic              locked;
  logic [IW-1:0]     lock_id;

  assign req = locked ? (c_srdy & ({{(inputs-1){1'b0}}, 1'b1} << lock_id)) : c_srdy;
`else
  assign req = c_srdy;
`endif

  // Search upward from ptr+1 with wrap-around; first requesting index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= inputs; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(inputs))
        cand = cand - (IW+1)'(inputs);
      if (!gnt_vld && req[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  assign gnt_oh = gnt_vld ? ({{(inputs-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign space  = (count < 2'd2);
  assign c_drdy = (space && reset_n) ? gnt_oh : '0;
  assign push   = gnt_vld && space;
  assign pop    = srdy_p1 && p_drdy;

  always_comb begin
    beat_data = '0;
    beat_eop  = 1'b0;
    for (int i = 0; i < inputs; i++) begin
      if (gnt_oh[i]) begin
        beat_data = c_data[i*width +: width];
        beat_eop  = c_eop[i];
      end
    end
  end

  // With one entry held, a simultaneous push and pop replaces the head directly.
  assign load_hd_beat = push && ((count == 2'd0) || ((count == 2'd1) && pop));
  assign load_hd_tail = pop && (count == 2'd2);
  assign load_tl      = push && !pop && (count == 2'd1);

  // Buffer occupancy, head control fields and arbitration state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= 2'd0;
      srdy_p1 <= 1'b0;
      hd_gnt  <= '0;
      hd_eop  <= 1'b0;
      ptr     <= IW'(inputs - 1);
`ifdef SD_RRARB_PKTLOCK_EN
      locked  <= 1'b0;
      lock_id <= '0;
`endif
    end else begin
      if (load_hd_beat) begin
        hd_gnt <= gnt_oh;
        hd_eop <= beat_eop;
      end else if (load_hd_tail) begin
        hd_gnt <= tl_gnt;
        hd_eop <= tl_eop;
      end else if (pop && (count == 2'd1)) begin
        hd_gnt <= '0;
        hd_eop <= 1'b0;
      end

      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;

      if (push && !pop)
        srdy_p1 <= 1'b1;
      else if (pop && !push && (count == 2'd1))
        srdy_p1 <= 1'b0;

      if (push) begin
        ptr <= gnt_idx;
`ifdef SD_RRARB_PKTLOCK_EN
        locked  <= !beat_eop;
        lock_id <= gnt_idx;
`endif
      end
    end
  end

  // Payload storage is not reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (load_hd_beat)
      hd_data <= beat_data;
    else if (load_hd_tail)
      hd_data <= tl_data;
    if (load_tl) begin
      tl_data <= beat_data;
      tl_eop  <= beat_eop;
      tl_gnt  <= gnt_oh;
    end
  end

  assign p_srdy  = srdy_p1;
  assign p_data  = hd_data;
  assign p_eop   = hd_eop;
  assign p_grant = hd_gnt;
endmodule

// File: tb/tb_sd_rrarb_full.sv
// Self-checking bench for sd_rrarb_full: directed scenarios plus random traffic against a queue-based model.
module tb_sd_rrarb_full;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   c_srdy, c_drdy, c_eop, p_grant;
  logic [N*W-1:0] c_data;
  logic           p_srdy, p_drdy, p_eop;
  logic [W-1:0]   p_data;

  always #5 clk = ~clk;

  sd_rrarb_full #(.inputs(N), .width(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_eop(c_eop),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_eop(p_eop),
    .p_grant(p_grant)
  );

  int n_chk = 0;
  int n_err = 0;

  bit         pend[N];
  logic [W-1:0] pdat[N];
  bit         peop[N];

  typedef struct { logic [W-1:0] d; bit e; int src; } beat_t;
  beat_t q[$];
  int ptr, lock_id, last_push, acc_cnt;
  bit locked;
  logic [N-1:0] pop_src[$];
  logic [W-1:0] pop_dat[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr = N - 1;
    locked = 1'b0;
    lock_id = 0;
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (pend[c] && (!locked || c == lock_id)) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      c_srdy[i]        = pend[i];
      c_data[i*W +: W] = pdat[i];
      c_eop[i]         = peop[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  // One clock cycle: check DUT against the model, then advance the model across the edge.
  task automatic step();
    int g;
    bit push, pop;
    logic [N-1:0] exp_drdy;
    drive();
    #1;
    g = pick();
    exp_drdy = '0;
    if (g >= 0 && q.size() < 2) exp_drdy[g] = 1'b1;
    chk("c_drdy", 32'(c_drdy), 32'(exp_drdy));
    chk("p_srdy", 32'(p_srdy), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("p_data", 32'(p_data), 32'(q[0].d));
      chk("p_eop", 32'(p_eop), 32'(q[0].e));
      chk("p_grant", 32'(p_grant), 32'(1 << q[0].src));
    end else begin
      chk("p_grant_idle", 32'(p_grant), 32'(0));
    end
    if ((c_srdy & c_drdy) != '0) acc_cnt++;
    push = (exp_drdy != '0);
    pop  = (q.size() > 0) && p_drdy;
    if (p_srdy && p_drdy) begin
      pop_src.push_back(p_grant);
      pop_dat.push_back(p_data);
    end
    @(posedge clk);
    if (pop) q.delete(0);
    last_push = -1;
    if (push) begin
      beat_t b;
      b.d = pdat[g]; b.e = peop[g]; b.src = g;
      q.push_back(b);
      ptr = g;
`ifdef SD_RRARB_PKTLOCK_EN
      locked  = !peop[g];
      lock_id = g;
`endif
      pend[g] = 1'b0;
      last_push = g;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_pend();
    drive();
    repeat (3) begin
      @(negedge clk);
      chk("rst_p_srdy", 32'(p_srdy), 32'(0));
      chk("rst_c_drdy", 32'(c_drdy), 32'(0));
      chk("rst_p_grant", 32'(p_grant), 32'(0));
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pdat[i] = W'(8'h10 + i); peop[i] = 1'b1;
    end
  endtask

  initial begin
    int sent1;
    int exp_order[5];
    reset_n = 1'b0;
    p_drdy  = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pdat[i] = '0; peop[i] = 0; end
    drive();
    model_reset();

    // Reset and idle
    do_reset();
    repeat (3) step();

    // Rotation at full rate
    p_drdy = 1'b1;
    pop_dat.delete();
    repeat (12) begin fill_all(); step(); end
    chk("rot_pops", 32'(pop_dat.size()), 32'(11));
    for (int k = 0; k < 8; k++) chk("rot_seq", 32'(pop_dat[k]), 32'(8'h10 + (k % 4)));
    clear_pend();
    repeat (3) step();

    // Backpressure then release
    do_reset();
    p_drdy = 1'b0;
    acc_cnt = 0;
    repeat (5) begin fill_all(); step(); end
    chk("bp_accepts", 32'(acc_cnt), 32'(2));
    p_drdy = 1'b1;
    pop_dat.delete();
    repeat (6) begin fill_all(); step(); end
    for (int k = 0; k < 4; k++) chk("bp_seq", 32'(pop_dat[k]), 32'(8'h10 + k));

    // Lone requester 3
    clear_pend();
    acc_cnt = 0;
    repeat (10) begin
      pend[3] = 1'b1; pdat[3] = W'($urandom); peop[3] = 1'b1;
      step();
    end
    chk("lone_accepts", 32'(acc_cnt), 32'(10));
    clear_pend();
    repeat (3) step();

    // Packet of three from requester 1 against continuous requester 2
    do_reset();
    p_drdy = 1'b1;
    pop_src.delete();
    sent1 = 0;
    repeat (10) begin
      if (!pend[1] && sent1 < 3) begin
        pend[1] = 1'b1; pdat[1] = W'(8'hA0 + sent1); peop[1] = (sent1 == 2);
      end
      pend[2] = 1'b1; pdat[2] = 8'hB0; peop[2] = 1'b1;
      step();
      if (last_push == 1) sent1++;
    end
`ifdef SD_RRARB_PKTLOCK_EN
    exp_order = '{1, 1, 1, 2, 2};
`else
    exp_order = '{1, 2, 1, 2, 1};
`endif
    for (int k = 0; k < 5; k++) chk("pkt_order", 32'(pop_src[k]), 32'(1 << exp_order[k]));
    clear_pend();
    repeat (3) step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1; pdat[i] = W'($urandom); peop[i] = ($urandom_range(2, 0) != 0);
        end
      end
      p_drdy = ($urandom_range(3, 0) != 0);
      step();
    end
    clear_pend();
    p_drdy = 1'b1;
    repeat (4) step();

    // Asynchronous reset while the buffer is full
    p_drdy = 1'b0;
    repeat (4) begin fill_all(); step(); end
    chk("full_before_rst", 32'(q.size()), 32'(2));
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_p_srdy", 32'(p_srdy), 32'(0));
    chk("async_c_drdy", 32'(c_drdy), 32'(0));
    chk("async_p_grant", 32'(p_grant), 32'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    fill_all();
    p_drdy = 1'b1;
    drive();
    #1;
    chk("post_rst_first", 32'(c_drdy), 32'(1));
    repeat (6) begin fill_all(); step(); end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
